// File: rtl/alu_shift_sched.sv
// alu_shift_sched
//   Shares one serial left-shift unit between two requesters and returns
//   res_y = (A << B) mod 2^OW, with A zero-extended to OW bits. A round-robin
//   arbiter picks a requester while IDLE. The shift then runs for exactly B
//   cycles, with no early exit. The result is held in DONE until the consumer
//   takes it.
//
// Parameters
//   W   operand width
//   OW  result width, must be 2*W
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req_valid  per-requester request valid (bit i = requester i)
//   req_ready  per-requester accept, one-hot or zero, only while IDLE
//   req0_a/b   requester 0 operands
//   req1_a/b   requester 1 operands
//   res_valid  result valid (DONE state)
//   res_ready  consumer accepts result
//   res_y      shift result (tracks the accumulator outside DONE)
//   res_id     requester that owns res_y
//   busy       FSM is not IDLE
module alu_shift_sched #(
  parameter int W  = 4,
  parameter int OW = 2 * W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [W-1:0]  req0_a,
  input  logic [W-1:0]  req0_b,
  input  logic [W-1:0]  req1_a,
  input  logic [W-1:0]  req1_b,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [OW-1:0] res_y,
  output logic          res_id,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [OW-1:0] acc;
  logic [W-1:0]  cnt;
  logic          last;   // index of the requester served most recently
  logic [1:0]    grant;
  logic          gsel;
  logic          accept;

  // Round-robin: on contention the requester that was not served last wins.
  always_comb begin
    grant = '0;
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  assign gsel      = grant[1];
  assign req_ready = (state == IDLE && !rst) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign res_y     = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      last      <= 1'b1;
      res_id    <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            acc    <= {{(OW-W){1'b0}}, (gsel ? req1_a : req0_a)};
            cnt    <= gsel ? req1_b : req0_b;
            res_id <= gsel;
            last   <= gsel;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          // The cnt==0 edge is the extra cycle that gives B+1 latency.
          if (cnt != '0) begin
            acc <= acc << 1;
            cnt <= cnt - 1'b1;
          end else begin
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
